// File: rtl/rst_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_ctrl_pkg : shared state encoding and cause-bit layout for the     |
// |                Sonata reset controller.                               |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    localparam int CauseW   = 3;
    localparam int CausePll = 0;
    localparam int CauseExt = 1;
    localparam int CauseSw  = 2;

endpackage
`default_nettype wire

// File: rtl/rst_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_debounce : synchroniser plus release filter for an active-low     |
// |                asynchronous reset input; assertion passes unfiltered. |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module rst_debounce #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_ni,
    output logic ok_o
);

    localparam int              CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ok_q, ok_d;
    logic                  in_s;

    assign in_s = sync_q[SyncStages-1];

    // Counter saturates at DebounceCycles-1; ok follows on the sample that would complete the run.
    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], in_ni};
        cnt_d  = '0;
        ok_d   = 1'b0;
        if (in_s) begin
            if (cnt_q == CntMax) begin
                cnt_d = cnt_q;
                ok_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            ok_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            ok_q   <= ok_d;
        end
    end

    assign ok_o = ok_q;

endmodule
`default_nettype wire

// File: rtl/rst_ctrl_sonata.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_ctrl_sonata : multi-domain reset controller; asserts all domains  |
// |                   together and releases them in staggered index order.|
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module rst_ctrl_sonata
    import rst_ctrl_pkg::*;
#(
    parameter int NumDomains       = 3,
    parameter int SyncStages       = 2,
    parameter int DebounceCycles   = 1000,
    parameter int LockStableCycles = 256,
    parameter int MinHoldCycles    = 16,
    parameter int ReleaseGap       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pll_locked_i,
    input  logic                  ext_rst_ni,
    input  logic                  sw_rst_req_i,
    output logic [NumDomains-1:0] rst_no,
    output logic                  rst_active_o,
    output logic [CauseW-1:0]     rst_cause_o
);

    localparam int HoldW = $clog2(MinHoldCycles + 1);
    localparam int LockW = $clog2(LockStableCycles + 1);
    localparam int GapW  = $clog2(ReleaseGap + 1);

    localparam logic [HoldW-1:0]      HoldMax = HoldW'(MinHoldCycles - 1);
    localparam logic [LockW-1:0]      LockMax = LockW'(LockStableCycles - 1);
    localparam logic [GapW-1:0]       GapMax  = GapW'(ReleaseGap - 1);
    localparam logic [NumDomains-1:0] One     = NumDomains'(1);

    rst_state_e            state_q, state_d;
    logic [SyncStages-1:0] pll_sync_q, pll_sync_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NumDomains-1:0] rst_q, rst_d;
    logic                  active_q, active_d;
    logic [CauseW-1:0]     cause_q, cause_d;
    logic [NumDomains-1:0] next_mask;

    logic pll_locked_s;
    logic ext_ok;
    logic src_bad;

    rst_debounce #(
        .SyncStages     (SyncStages),
        .DebounceCycles (DebounceCycles)
    ) u_ext_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_ni  (ext_rst_ni),
        .ok_o   (ext_ok)
    );

    assign pll_locked_s = pll_sync_q[SyncStages-1];
    assign src_bad      = !pll_locked_s | !ext_ok | sw_rst_req_i;
    assign next_mask    = (rst_q << 1) | One;

    always_comb begin
        pll_sync_d = {pll_sync_q[SyncStages-2:0], pll_locked_i};
        state_d    = state_q;
        hold_cnt_d = '0;
        lock_cnt_d = '0;
        gap_cnt_d  = '0;
        rst_d      = rst_q;
        cause_d    = cause_q;

        unique case (state_q)
            HOLD: begin
                if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end else if (!src_bad) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            WAIT_LOCK: begin
                if (src_bad) begin
                    state_d = HOLD;
                end else if (lock_cnt_q == LockMax) begin
                    rst_d   = One;
                    state_d = (NumDomains == 1) ? RUN : RELEASE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
            end
            RELEASE: begin
                if (src_bad) begin
                    state_d = HOLD;
                end else if (gap_cnt_q == GapMax) begin
                    rst_d = next_mask;
                    if (&next_mask) begin
                        state_d = RUN;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            RUN: begin
                if (src_bad) begin
                    state_d           = HOLD;
                    cause_d           = '0;
                    cause_d[CausePll] = !pll_locked_s;
                    cause_d[CauseExt] = !ext_ok;
                    cause_d[CauseSw]  = sw_rst_req_i;
                end
            end
            default: state_d = HOLD;
        endcase

        // Any path into HOLD drops every domain on the same edge, overriding a pending release.
        if (state_d == HOLD) begin
            rst_d = '0;
        end
        active_d = ~&rst_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= HOLD;
            pll_sync_q <= '0;
            hold_cnt_q <= '0;
            lock_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rst_q      <= '0;
            active_q   <= 1'b1;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            pll_sync_q <= pll_sync_d;
            hold_cnt_q <= hold_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rst_q      <= rst_d;
            active_q   <= active_d;
            cause_q    <= cause_d;
        end
    end

    assign rst_no       = rst_q;
    assign rst_active_o = active_q;
    assign rst_cause_o  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_ctrl_sonata.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rst_ctrl_sonata : directed vectors and corner sequences for the    |
// |                      reset controller (3 domains, short timings).     |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_rst_ctrl_sonata;

    logic       clk;
    logic       rst_n;
    logic       pll;
    logic       ext_n;
    logic       sw;
    logic [2:0] rst_no;
    logic       rst_active;
    logic [2:0] rst_cause;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [2:0] prev_rst = 3'b000;

    typedef struct packed {
        logic       sw;
        logic       pll;
        logic       ext;
        logic [2:0] exp_rst;
        logic [2:0] exp_cause;
    } vec_t;

    vec_t vecs[$];

    rst_ctrl_sonata #(
        .NumDomains       (3),
        .SyncStages       (2),
        .DebounceCycles   (8),
        .LockStableCycles (4),
        .MinHoldCycles    (4),
        .ReleaseGap       (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_locked_i (pll),
        .ext_rst_ni   (ext_n),
        .sw_rst_req_i (sw),
        .rst_no       (rst_no),
        .rst_active_o (rst_active),
        .rst_cause_o  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock edge; outputs are examined 1 time unit later and the release order is policed.
    task automatic tick();
        logic ok;
        @(posedge clk);
        #1;
        cyc++;
        ok = (rst_no == prev_rst) || (rst_no == 3'b000) ||
             (rst_no == ((prev_rst << 1) | 3'b001));
        chk("order", {31'd0, ok}, 32'd1);
        prev_rst = rst_no;
    endtask

    task automatic add(input int n, input logic s, input logic p, input logic e,
                       input logic [2:0] er, input logic [2:0] ec);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.sw = s; v.pll = p; v.ext = e; v.exp_rst = er; v.exp_cause = ec;
            vecs.push_back(v);
        end
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sw    = vecs[i].sw;
            pll   = vecs[i].pll;
            ext_n = vecs[i].ext;
            tick();
            chk("vec_rst_no", rst_no, vecs[i].exp_rst);
            chk("vec_active", rst_active, (vecs[i].exp_rst != 3'b111));
            chk("vec_cause", rst_cause, vecs[i].exp_cause);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_rst_no", rst_no, 3'b000);
        chk("rst_active", rst_active, 1'b1);
        chk("rst_cause", rst_cause, 3'b000);
    endtask

    initial begin
        int t;
        // Power-on: cycles 1..20, released 001@15, 011@17, 111@19.
        add(14, 0, 1, 1, 3'b000, 3'b000);
        add(2,  0, 1, 1, 3'b001, 3'b000);
        add(2,  0, 1, 1, 3'b011, 3'b000);
        add(2,  0, 1, 1, 3'b111, 3'b000);
        // Software pulse sampled at cycle 21: drop at 21, bit0 at 29.
        add(1,  1, 1, 1, 3'b000, 3'b100);
        add(7,  0, 1, 1, 3'b000, 3'b100);
        add(2,  0, 1, 1, 3'b001, 3'b100);
        add(2,  0, 1, 1, 3'b011, 3'b100);
        add(2,  0, 1, 1, 3'b111, 3'b100);

        rst_n = 1'b0; pll = 1'b1; ext_n = 1'b1; sw = 1'b0;
        repeat (3) tick();
        chk_reset_state();
        rst_n = 1'b1;
        cyc   = 0;
        run_vectors(0, vecs.size() - 1);

        // PLL glitch from RUN, then a second glitch while waiting for lock.
        t = cyc;
        pll = 1'b0; tick(); pll = 1'b1;
        tick();
        chk("pll_still_run", rst_no, 3'b111);
        tick();
        chk("pll_drop", rst_no, 3'b000);
        chk("pll_cause", rst_cause, 3'b001);
        repeat (4) tick();
        pll = 1'b0; tick(); pll = 1'b1;
        repeat (9) tick();
        chk("flap_held", rst_no, 3'b000);
        chk("flap_cause", rst_cause, 3'b001);
        tick();
        chk("flap_release", rst_no, 3'b001);
        repeat (4) tick();
        chk("flap_run", rst_no, 3'b111);
        chk("flap_elapsed", cyc - t, 22);

        // Button bounce: 3-cycle toggles for 30 cycles, then steady high.
        t = cyc;
        for (int p = 0; p < 10; p++) begin
            ext_n = (p % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (cyc - t >= 5) chk("bounce_hold", rst_no, 3'b000);
            end
        end
        chk("bounce_cause", rst_cause, 3'b010);
        repeat (11) tick();
        chk("bounce_settle", rst_no, 3'b000);
        tick();
        chk("bounce_release", rst_no, 3'b001);
        repeat (4) tick();
        chk("bounce_run", rst_no, 3'b111);
        chk("bounce_cause_kept", rst_cause, 3'b010);

        // Software request on the same edge that would release domain 1.
        pll = 1'b0; tick(); pll = 1'b1;
        repeat (2) tick();
        chk("race_drop", rst_no, 3'b000);
        chk("race_cause", rst_cause, 3'b001);
        repeat (8) tick();
        chk("race_bit0", rst_no, 3'b001);
        tick();
        chk("race_bit0_hold", rst_no, 3'b001);
        sw = 1'b1; tick(); sw = 1'b0;
        chk("race_abort", rst_no, 3'b000);
        chk("race_cause_kept", rst_cause, 3'b001);
        tick();
        chk("race_stays", rst_no, 3'b000);
        repeat (6) tick();
        chk("race_hold_end", rst_no, 3'b000);
        tick();
        chk("race_rerelease", rst_no, 3'b001);
        chk("race_cause_final", rst_cause, 3'b001);

        // Controller reset in the middle of RELEASE, then the power-on sequence again.
        rst_n = 1'b0;
        tick();
        chk_reset_state();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        run_vectors(0, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
